// File: rtl/bus_xfer_monitor.sv
// Passive decoder of tri-state bus enables into a show-ahead FIFO of transfer records.
// Define XFERMON_SWAP_DETECT_EN to build the three-transfer swap detector.
module bus_xfer_monitor #(
    parameter int DEPTH = 8
) (
    input  logic                     Clock,
    input  logic                     reset,
    input  logic                     Extern,
    input  logic                     R1out,
    input  logic                     R2out,
    input  logic                     R3out,
    input  logic                     R1in,
    input  logic                     R2in,
    input  logic                     R3in,
    input  logic [7:0]               bus,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [12:0]              rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     contention,
    output logic                     float_load,
    output logic [7:0]               err_cnt,
    output logic                     swap_done,
    output logic [1:0]               swap_a,
    output logic [1:0]               swap_b
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [2:0]  n_src;
    logic [2:0]  dst;
    logic [1:0]  src;
    logic        is_cont, is_float, is_xfer;
    logic [12:0] rec;

    assign n_src = {2'b00, Extern} + {2'b00, R1out} +
                   {2'b00, R2out} + {2'b00, R3out};
    assign dst = {R3in, R2in, R1in};
    assign src = R3out ? 2'd3 : R2out ? 2'd2 : R1out ? 2'd1 : 2'd0;
    assign is_cont  = n_src >= 3'd2;
    assign is_float = (n_src == 3'd0) && (dst != 3'b000);
    assign is_xfer  = (n_src == 3'd1) && (dst != 3'b000);
    assign rec = {src, dst, bus};

    logic [12:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, contention_q, float_q;
    logic [7:0]    err_q;
    logic          full, pop, push;

    assign full = count_q == FULL_CNT;
    assign pop  = rd_en && (count_q != '0);
    // A pop in the same cycle frees the slot the write needs.
    assign push = is_xfer && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
    end

    always_ff @(posedge Clock) begin
        if (push)
            mem_q[wr_ptr_q] <= rec;
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            contention_q <= 1'b0;
            float_q      <= 1'b0;
            err_q        <= 8'd0;
        end else begin
            count_q <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            if (is_xfer && full && !pop)
                overflow_q <= 1'b1;
            if (is_float)
                float_q <= 1'b1;
            if (is_cont) begin
                contention_q <= 1'b1;
                if (err_q != 8'hFF)
                    err_q <= err_q + 8'd1;
            end
        end
    end

    assign rd_valid   = count_q != '0;
    assign rd_data    = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign contention = contention_q;
    assign float_load = float_q;
    assign err_cnt    = err_q;

`ifdef XFERMON_SWAP_DETECT_EN
    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2} state_t;

    state_t     state_q;
    logic [1:0] a_q, b_q;
    logic       swap_done_q;
    logic [1:0] swap_a_q, swap_b_q;
    logic       start, step2, step3;
    logic [2:0] a_mask, b_mask;

    assign a_mask = 3'b001 << (a_q - 2'd1);
    assign b_mask = 3'b001 << (b_q - 2'd1);
    assign start  = (src == 2'd1 || src == 2'd2) && dst == 3'b100;
    assign step2  = (src == 2'd1 || src == 2'd2) && src != a_q && dst == a_mask;
    assign step3  = src == 2'd3 && dst == b_mask;

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= 2'd0;
            b_q         <= 2'd0;
            swap_done_q <= 1'b0;
            swap_a_q    <= 2'd0;
            swap_b_q    <= 2'd0;
        end else begin
            swap_done_q <= 1'b0;
            if (is_cont || is_float) begin
                state_q <= S_IDLE;
            end else if (is_xfer) begin
                // A broken sequence may itself be the first step of a new one.
                if (state_q == S_T2 && step3) begin
                    swap_done_q <= 1'b1;
                    swap_a_q    <= a_q;
                    swap_b_q    <= b_q;
                    state_q     <= S_IDLE;
                end else if (state_q == S_T1 && step2) begin
                    b_q     <= src;
                    state_q <= S_T2;
                end else if (start) begin
                    a_q     <= src;
                    state_q <= S_T1;
                end else begin
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign swap_done = swap_done_q;
    assign swap_a    = swap_a_q;
    assign swap_b    = swap_b_q;
`else
    assign swap_done = 1'b0;
    assign swap_a    = 2'd0;
    assign swap_b    = 2'd0;
`endif
endmodule

// File: tb/tb_bus_xfer_monitor.sv
// Scoreboard bench for bus_xfer_monitor: random and directed bus cycles
// checked against a queue-based reference model of the transfer rules.
module tb_bus_xfer_monitor;
    localparam int DEPTH = 8;

    logic        Clock = 1'b0;
    logic        reset = 1'b1;
    logic        Extern = 1'b0, R1out = 1'b0, R2out = 1'b0, R3out = 1'b0;
    logic        R1in = 1'b0, R2in = 1'b0, R3in = 1'b0;
    logic [7:0]  bus = 8'd0;
    logic        rd_en = 1'b0;
    logic        rd_valid;
    logic [12:0] rd_data;
    logic [3:0]  count;
    logic        overflow, contention, float_load;
    logic [7:0]  err_cnt;
    logic        swap_done;
    logic [1:0]  swap_a, swap_b;

    bus_xfer_monitor #(.DEPTH(DEPTH)) dut (
        .Clock(Clock), .reset(reset),
        .Extern(Extern), .R1out(R1out), .R2out(R2out), .R3out(R3out),
        .R1in(R1in), .R2in(R2in), .R3in(R3in), .bus(bus),
        .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
        .count(count), .overflow(overflow), .contention(contention),
        .float_load(float_load), .err_cnt(err_cnt),
        .swap_done(swap_done), .swap_a(swap_a), .swap_b(swap_b)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad = 0;

    logic [12:0] sb[$];
    logic [12:0] hist[$];
    int   m_ovf = 0, m_cont = 0, m_flt = 0, m_err = 0;
    int   m_sd = 0, m_sa = 0, m_sb = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int dst_of(input int r);
        return (r == 1) ? 1 : (r == 2) ? 2 : (r == 3) ? 4 : 0;
    endfunction

    // Reference model: evaluated on the inputs present at each rising edge.
    initial begin
        forever begin
            int nsrc, s, ld, a, b;
            logic [3:0] srcs;
            logic [12:0] r, h0, h1, h2;
            @(posedge Clock);
            srcs = {R3out, R2out, R1out, Extern};
            ld = {29'd0, R3in, R2in, R1in};
            if (reset) begin
                sb.delete(); hist.delete();
                m_ovf = 0; m_cont = 0; m_flt = 0; m_err = 0;
                m_sd = 0; m_sa = 0; m_sb = 0;
            end else begin
                m_sd = 0;
                nsrc = $countones(srcs);
                if (rd_en && sb.size() > 0) void'(sb.pop_front());
                if (nsrc >= 2) begin
                    m_cont = 1;
                    if (m_err < 255) m_err++;
                    hist.delete();
                end else if (nsrc == 0 && ld != 0) begin
                    m_flt = 1;
                    hist.delete();
                end else if (nsrc == 1 && ld != 0) begin
                    s = 0;
                    for (int k = 0; k < 4; k++) if (srcs[k]) s = k;
                    r = {s[1:0], ld[2:0], bus};
                    if (sb.size() < DEPTH) sb.push_back(r);
                    else m_ovf = 1;
`ifdef XFERMON_SWAP_DETECT_EN
                    hist.push_back(r);
                    if (hist.size() > 3) void'(hist.pop_front());
                    if (hist.size() == 3) begin
                        h0 = hist[0]; h1 = hist[1]; h2 = hist[2];
                        a = int'(h0[12:11]);
                        b = int'(h1[12:11]);
                        if ((a == 1 || a == 2) && h0[10:8] == 3'b100 &&
                            (b == 1 || b == 2) && b != a &&
                            int'(h1[10:8]) == dst_of(a) &&
                            h2[12:11] == 2'd3 && int'(h2[10:8]) == dst_of(b)) begin
                            m_sd = 1; m_sa = a; m_sb = b;
                        end
                    end
`endif
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model between edges.
    initial begin
        forever begin
            @(negedge Clock);
            chk("rd_valid", rd_valid, sb.size() != 0);
            chk("count", count, sb.size());
            if (rd_valid && sb.size() != 0) chk("rd_data", rd_data, sb[0]);
            chk("overflow", overflow, m_ovf);
            chk("contention", contention, m_cont);
            chk("float_load", float_load, m_flt);
            chk("err_cnt", err_cnt, m_err);
            chk("swap_done", swap_done, m_sd);
            chk("swap_a", swap_a, m_sa);
            chk("swap_b", swap_b, m_sb);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic [3:0] s, input logic [2:0] l,
                         input logic [7:0] b, input logic rd);
        {R3out, R2out, R1out, Extern} = s;
        {R3in, R2in, R1in} = l;
        bus = b;
        rd_en = rd;
        @(negedge Clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0, 3'b0, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    task automatic rnd(input int rdp, input bit swapmode, input bit rst_ok);
        int m, k;
        logic [3:0] s;
        logic [2:0] l;
        logic [3:0] stab [6];
        logic [2:0] dtab [6];
        stab = '{4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b1000, 4'b1000};
        dtab = '{3'b100, 3'b100, 3'b001, 3'b010, 3'b001, 3'b010};
        m = $urandom_range(0, 11);
        s = 4'b0;
        l = 3'b0;
        if (m == 0) begin
            s = 4'($urandom_range(0, 15));
            while ($countones(s) < 2) s = 4'($urandom_range(0, 15));
            l = 3'($urandom_range(0, 7));
        end else if (m == 1) begin
            l = 3'($urandom_range(1, 7));
        end else if (m == 2) begin
            s = 4'b0001 << $urandom_range(0, 3);
        end else if (m == 3) begin
            s = 4'b0;
        end else if (swapmode && m > 5) begin
            k = $urandom_range(0, 5);
            s = stab[k];
            l = dtab[k];
        end else begin
            s = 4'b0001 << $urandom_range(0, 3);
            l = 3'($urandom_range(1, 7));
        end
        reset = rst_ok && ($urandom_range(0, 149) == 0);
        drive(s, l, 8'($urandom), $urandom_range(0, 99) < rdp);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset rd_valid", rd_valid, 0);
        chk("reset count", count, 0);

        drive(4'b0001, 3'b001, 8'hA5, 1'b0);
        chk("first rd_valid", rd_valid, 1);
        chk("first rd_data", rd_data, 13'h01A5);
        chk("first count", count, 1);

        repeat (3) drive(4'b0110, 3'b000, 8'h00, 1'b0);
        chk("cont flag", contention, 1);
        chk("cont err_cnt", err_cnt, 3);
        chk("cont count", count, 1);
        do_reset();
        chk("rst contention", contention, 0);
        chk("rst err_cnt", err_cnt, 0);
        chk("rst count", count, 0);

        drive(4'b0000, 3'b010, 8'h3C, 1'b0);
        chk("float flag", float_load, 1);
        chk("float count", count, 0);

        for (int i = 0; i < DEPTH + 2; i++)
            drive(4'b0100, 3'b101, 8'(8'h10 + i), 1'b0);
        chk("fill count", count, DEPTH);
        chk("fill overflow", overflow, 1);
        for (int i = 0; i < DEPTH; i++) drive(4'b0, 3'b0, 8'h00, 1'b1);
        chk("drained rd_valid", rd_valid, 0);
        drive(4'b0, 3'b0, 8'h00, 1'b1);
        chk("empty pop count", count, 0);

        do_reset();
        for (int i = 0; i < DEPTH; i++)
            drive(4'b1000, 3'b001, 8'(8'h40 + i), 1'b0);
        drive(4'b0001, 3'b110, 8'hEE, 1'b1);
        chk("full rw count", count, DEPTH);
        chk("full rw overflow", overflow, 0);
        for (int i = 0; i < DEPTH; i++) drive(4'b0, 3'b0, 8'h00, 1'b1);

        do_reset();
        drive(4'b0010, 3'b100, 8'h01, 1'b0);
        drive(4'b0000, 3'b000, 8'h00, 1'b0);
        drive(4'b0100, 3'b001, 8'h02, 1'b0);
        drive(4'b1000, 3'b010, 8'h03, 1'b0);
`ifdef XFERMON_SWAP_DETECT_EN
        chk("swap pulse", swap_done, 1);
        chk("swap a", swap_a, 1);
        chk("swap b", swap_b, 2);
`else
        chk("swap off", swap_done, 0);
`endif
        drive(4'b0, 3'b0, 8'h00, 1'b1);
        chk("swap pulse end", swap_done, 0);
        drive(4'b0010, 3'b100, 8'h04, 1'b1);
        drive(4'b0100, 3'b001, 8'h05, 1'b1);
        drive(4'b0001, 3'b001, 8'h06, 1'b1);
        drive(4'b1000, 3'b010, 8'h07, 1'b1);
        chk("broken swap", swap_done, 0);

        do_reset();
        repeat (600) rnd(0, 1'b0, 1'b0);
        repeat (1500) rnd(50, 1'b0, 1'b1);
        repeat (1500) rnd(85, 1'b1, 1'b1);
        repeat (800) rnd(30, 1'b1, 1'b0);

        do_reset();
        repeat (260) drive(4'b1111, 3'b111, 8'hFF, 1'b0);
        chk("err saturate", err_cnt, 255);

        @(negedge Clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
